// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: datapath width, condition codes,
// flag bit positions inside the {Z,C,V,S,Nf} vector, FSM states and a
// saturating counter helper.
package branch_resolver_pkg;

  localparam int N      = 16;
  localparam int NFLAGS = 5;

  localparam logic [2:0] COND_EQ     = 3'd0;
  localparam logic [2:0] COND_NE     = 3'd1;
  localparam logic [2:0] COND_LT     = 3'd2;
  localparam logic [2:0] COND_GE     = 3'd3;
  localparam logic [2:0] COND_LTU    = 3'd4;
  localparam logic [2:0] COND_GEU    = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [N-1:0] sat_inc(input logic [N-1:0] v);
    return (v == {N{1'b1}}) ? v : v + {{(N-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// Combinational branch-condition evaluator. C uses the subtract convention
// (C=1 means no borrow), so unsigned-less-than is !C. S is the true sign of
// the result, so signed compares need no V correction here.
module cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [NFLAGS-1:0] flags_i,
  input  logic [2:0]        cond_i,
  output logic              taken_o
);

  // Select the flag term named by the condition code.
  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_EQ:     taken_o =  flags_i[FLAG_Z];
      COND_NE:     taken_o = ~flags_i[FLAG_Z];
      COND_LT:     taken_o =  flags_i[FLAG_S];
      COND_GE:     taken_o = ~flags_i[FLAG_S];
      COND_LTU:    taken_o = ~flags_i[FLAG_C];
      COND_GEU:    taken_o =  flags_i[FLAG_C];
      COND_ALWAYS: taken_o = 1'b1;
      COND_NEVER:  taken_o = 1'b0;
      default:     taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: captures EX-stage ALU flags, evaluates branch conditions
// with same-cycle flag bypass, and issues a held PC redirect to fetch.
// Optional feature macro BRANCH_RESOLVER_STATS_EN adds saturating counters
// stat_resolved / stat_taken.
module branch_resolver
  import branch_resolver_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic [N-1:0]      alu_s,
  input  logic              alu_cout,
  input  logic              alu_ovf,
  input  logic              alu_sign,
  input  logic              alu_negative,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  input  logic [N-1:0]      br_target,
  output logic              br_ready,
  input  logic              flush,
  output logic [NFLAGS-1:0] flags,
  output logic              resolve_valid,
  output logic              resolve_taken,
  output logic              redirect_valid,
  output logic [N-1:0]      redirect_pc,
  input  logic              redirect_ready
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [N-1:0]      stat_resolved,
  output logic [N-1:0]      stat_taken
`endif
);

  state_e            state_q;
  logic              br_ready_q;
  logic              resolve_valid_q;
  logic              resolve_taken_q;
  logic              redirect_valid_q;
  logic [N-1:0]      redirect_pc_q;
  logic [NFLAGS-1:0] flags_q;

  logic [NFLAGS-1:0] alu_flags;
  logic [NFLAGS-1:0] eff_flags;
  logic              taken;
  logic              accept;

  assign alu_flags = {(alu_s == '0), alu_cout, alu_ovf, alu_sign, alu_negative};
  assign eff_flags = flag_we ? alu_flags : flags_q;
  // A flushed request is treated as if it never arrived.
  assign accept    = br_valid & br_ready_q & ~flush;

  cond_eval u_cond_eval (
    .flags_i (eff_flags),
    .cond_i  (br_cond),
    .taken_o (taken)
  );

  // Flag register: written whenever the ALU result is valid, untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (flag_we) begin
      flags_q <= alu_flags;
    end
  end

  // Control FSM with registered handshake and resolve outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      br_ready_q       <= 1'b1;
      resolve_valid_q  <= 1'b0;
      resolve_taken_q  <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else begin
      resolve_valid_q <= accept;
      resolve_taken_q <= accept & taken;
      case (state_q)
        ST_IDLE: begin
          if (accept && taken) begin
            state_q          <= ST_REDIRECT;
            br_ready_q       <= 1'b0;
            redirect_valid_q <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          if (flush || redirect_ready) begin
            state_q          <= ST_IDLE;
            br_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= ST_IDLE;
          br_ready_q       <= 1'b1;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Redirect target: loaded only by a taken accept, so it holds while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc_q <= '0;
    end else if (accept && taken) begin
      redirect_pc_q <= br_target;
    end
  end

  assign br_ready       = br_ready_q;
  assign flags          = flags_q;
  assign resolve_valid  = resolve_valid_q;
  assign resolve_taken  = resolve_taken_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [N-1:0] stat_resolved_q;
  logic [N-1:0] stat_taken_q;

  // Counters advance on the accept edge, matching the resolve pulse one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved_q <= '0;
      stat_taken_q    <= '0;
    end else if (accept) begin
      stat_resolved_q <= sat_inc(stat_resolved_q);
      if (taken) begin
        stat_taken_q <= sat_inc(stat_taken_q);
      end
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_taken    = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed branches push their
// hand-computed outcome into a queue; a monitor pops and compares on every
// resolve pulse and also watches redirect stability under back-pressure.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          flag_we;
  logic [N-1:0]  alu_s;
  logic          alu_cout, alu_ovf, alu_sign, alu_negative;
  logic          br_valid;
  logic [2:0]    br_cond;
  logic [N-1:0]  br_target;
  logic          br_ready;
  logic          flush;
  logic [4:0]    flags;
  logic          resolve_valid, resolve_taken;
  logic          redirect_valid;
  logic [N-1:0]  redirect_pc;
  logic          redirect_ready;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [N-1:0]  stat_resolved, stat_taken;
`endif

  branch_resolver dut (
    .clk            (clk),
    .rst            (rst),
    .flag_we        (flag_we),
    .alu_s          (alu_s),
    .alu_cout       (alu_cout),
    .alu_ovf        (alu_ovf),
    .alu_sign       (alu_sign),
    .alu_negative   (alu_negative),
    .br_valid       (br_valid),
    .br_cond        (br_cond),
    .br_target      (br_target),
    .br_ready       (br_ready),
    .flush          (flush),
    .flags          (flags),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .stat_resolved  (stat_resolved),
    .stat_taken     (stat_taken)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         taken;
    logic [N-1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   taken_cnt = 0;
  logic         hold_prev = 1'b0;
  logic [N-1:0] pc_prev   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] cond, input logic [N-1:0] tgt,
                       input logic exp_taken);
    exp_t e;
    br_valid  = 1'b1;
    br_cond   = cond;
    br_target = tgt;
    e.taken   = exp_taken;
    e.pc      = tgt;
    exp_q.push_back(e);
  endtask

  task automatic set_alu(input logic [N-1:0] s, input logic c, input logic v,
                         input logic sg, input logic ng);
    flag_we = 1'b1; alu_s = s; alu_cout = c; alu_ovf = v; alu_sign = sg; alu_negative = ng;
  endtask

  // Monitor: compare each resolve pulse against the scoreboard and check redirect hold.
  always @(negedge clk) begin
    exp_t e;
    if (hold_prev) begin
      chk("redirect_hold_valid", {31'd0, redirect_valid}, 32'd1);
      chk("redirect_hold_pc", {16'd0, redirect_pc}, {16'd0, pc_prev});
    end
    hold_prev = redirect_valid & ~redirect_ready & ~flush & ~rst;
    pc_prev   = redirect_pc;
    if (resolve_valid === 1'b1) begin
      pulses++;
      if (resolve_taken === 1'b1) taken_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_resolve", {31'd0, resolve_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resolve_taken", {31'd0, resolve_taken}, {31'd0, e.taken});
        if (e.taken) begin
          chk("redirect_valid", {31'd0, redirect_valid}, 32'd1);
          chk("redirect_pc", {16'd0, redirect_pc}, {16'd0, e.pc});
        end
      end
    end
  end

  initial begin
    int p0;
    rst = 1'b1; flag_we = 1'b0; alu_s = '0; alu_cout = 0; alu_ovf = 0; alu_sign = 0;
    alu_negative = 0; br_valid = 0; br_cond = '0; br_target = '0; flush = 0;
    redirect_ready = 1'b1;
    tick(); tick();
    chk("rst_flags", {27'd0, flags}, 32'd0);
    chk("rst_br_ready", {31'd0, br_ready}, 32'd1);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_resolve_valid", {31'd0, resolve_valid}, 32'd0);
    chk("rst_redirect_pc", {16'd0, redirect_pc}, 32'd0);
    rst = 1'b0;
    tick();

    // Bypass: zero result and EQ branch in the same cycle.
    set_alu(16'h0000, 0, 0, 0, 0);
    issue(COND_EQ, 16'h0040, 1'b1);
    tick();
    flag_we = 0; br_valid = 0;
    chk("bypass_flags", {27'd0, flags}, 32'h10);
    tick();
    chk("bypass_ready_back", {31'd0, br_ready}, 32'd1);

    // Signed compare from 0x7FFF - 0xFFFF: result 0x8000, C=0, V=1, S=0, Nf=1.
    set_alu(16'h8000, 0, 1, 0, 1);
    tick();
    flag_we = 0;
    chk("sub_flags", {27'd0, flags}, 32'h05);
    issue(COND_LT, 16'h0100, 1'b0);
    tick();
    issue(COND_GE, 16'h0200, 1'b1);
    tick();
    br_valid = 0;
    tick();

    // Back-pressure on a taken redirect.
    redirect_ready = 0;
    issue(COND_ALWAYS, 16'h1234, 1'b1);
    tick();
    br_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", {31'd0, redirect_valid}, 32'd1);
      chk("bp_pc", {16'd0, redirect_pc}, 32'h1234);
      chk("bp_br_ready", {31'd0, br_ready}, 32'd0);
      tick();
    end
    redirect_ready = 1;
    tick();
    chk("bp_release_valid", {31'd0, redirect_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, br_ready}, 32'd1);

    // Flush in REDIRECT together with redirect_ready.
    redirect_ready = 0;
    issue(COND_ALWAYS, 16'h0ABC, 1'b1);
    tick();
    br_valid = 0;
    flush = 1; redirect_ready = 1;
    tick();
    flush = 0;
    chk("flush_redir_valid", {31'd0, redirect_valid}, 32'd0);
    chk("flush_redir_ready", {31'd0, br_ready}, 32'd1);
    tick();
    chk("flush_no_redirect", {31'd0, redirect_valid}, 32'd0);

    // Flush with a request in the same cycle: dropped, no resolve.
    br_valid = 1; br_cond = COND_ALWAYS; br_target = 16'hDEAD; flush = 1;
    tick();
    br_valid = 0; flush = 0;
    chk("flush_req_resolve", {31'd0, resolve_valid}, 32'd0);
    chk("flush_req_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("flush_keeps_flags", {27'd0, flags}, 32'h05);

    // Not-taken streaming: Z=1, four NE branches back-to-back.
    set_alu(16'h0000, 0, 0, 0, 0);
    tick();
    flag_we = 0;
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      issue(COND_NE, 16'h0500 + 16'(i), 1'b0);
      chk("stream_br_ready", {31'd0, br_ready}, 32'd1);
      tick();
    end
    br_valid = 0;
    tick();
    chk("stream_pulses", pulses - p0, 32'd4);

    // Unsigned: C=1 via bypass -> LTU not taken; GEU from register taken; NEVER.
    set_alu(16'h0005, 1, 0, 0, 0);
    issue(COND_LTU, 16'h0300, 1'b0);
    tick();
    flag_we = 0;
    issue(COND_GEU, 16'h0310, 1'b1);
    tick();
    br_valid = 0;
    tick();
    issue(COND_NEVER, 16'h0320, 1'b0);
    tick();
    br_valid = 0;
    tick();

`ifdef BRANCH_RESOLVER_STATS_EN
    chk("stat_resolved", {16'd0, stat_resolved}, 32'd12);
    chk("stat_taken", {16'd0, stat_taken}, 32'd5);
`endif

    // Reset while a redirect is waiting drops it.
    redirect_ready = 0;
    issue(COND_ALWAYS, 16'h0777, 1'b1);
    tick();
    br_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, br_ready}, 32'd1);
    chk("rst_mid_flags", {27'd0, flags}, 32'd0);
    redirect_ready = 1;
    tick(); tick();

    chk("total_pulses", pulses, 32'd13);
    chk("total_taken", taken_cnt, 32'd6);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
